// File: rtl/nibble_serial_adder16_if.sv
// nibble_serial_adder16_if: operand/result bus of the nibble-serial adder.
// Carries use_carry only when NIBBLE_ADDER_CARRY_CHAIN_EN is defined.
interface nibble_serial_adder16_if;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
`ifdef NIBBLE_ADDER_CARRY_CHAIN_EN
    logic        use_carry;
`endif
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        overflow;
    logic        zero;
    modport master (
`ifdef NIBBLE_ADDER_CARRY_CHAIN_EN
        output use_carry,
`endif
        output start, sub, a, b,
        input  busy, done, result, cout, overflow, zero
    );
    modport slave (
`ifdef NIBBLE_ADDER_CARRY_CHAIN_EN
        input  use_carry,
`endif
        input  start, sub, a, b,
        output busy, done, result, cout, overflow, zero
    );
endinterface

// File: rtl/nibble_serial_adder16.sv
// nibble_serial_adder16: 16-bit add/sub through one 4-bit slice, one nibble per clock.
// NIBBLE_ADDER_CARRY_CHAIN_EN adds use_carry (initial carry = previous cout).
module nibble_serial_adder16 #(
    parameter int NIBBLES = 4
) (
    input logic clk,
    input logic reset,
    nibble_serial_adder16_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state, state_n;
    logic [1:0]  cnt;
    logic [15:0] ra, rb, acc;
    logic        c, cin, accept, last;
    logic [3:0]  idx;
    logic [4:0]  s;
    assign accept = bus.start && state != RUN;
    assign last   = cnt == 2'(NIBBLES - 1);
    assign idx    = {cnt, 2'b00};
    assign s      = {1'b0, ra[idx +: 4]} + {1'b0, rb[idx +: 4]} + {4'b0, c};
`ifdef NIBBLE_ADDER_CARRY_CHAIN_EN
    assign cin = bus.use_carry ? bus.cout : bus.sub;
`else
    assign cin = bus.sub;
`endif
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;
    always_comb
        state_n = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
    always_comb begin
        bus.busy = state == RUN;
        bus.done = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            c            <= 1'b0;
            ra           <= '0;
            rb           <= '0;
            acc          <= '0;
            bus.result   <= '0;
            bus.cout     <= 1'b0;
            bus.overflow <= 1'b0;
            bus.zero     <= 1'b0;
        end else if (accept) begin
            ra  <= bus.a;
            rb  <= bus.sub ? ~bus.b : bus.b;
            c   <= cin;
            cnt <= '0;
        end else if (state == RUN) begin
            acc[idx +: 4] <= s[3:0];
            c             <= s[4];
            cnt           <= cnt + 2'd1;
            if (last) begin
                bus.result   <= {s[3:0], acc[11:0]};
                bus.cout     <= s[4];
                bus.overflow <= (ra[15] == rb[15]) && (s[3] != ra[15]);
                bus.zero     <= {s[3:0], acc[11:0]} == 16'h0000;
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder16.sv
// tb_nibble_serial_adder16: directed vectors, scoreboard queue checked by a done monitor.
module tb_nibble_serial_adder16;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    int   lat;
    typedef struct packed {
        logic [15:0] r;
        logic        c, v, z;
    } exp_t;
    exp_t q[$];
    exp_t e;
    nibble_serial_adder16_if bus();
    nibble_serial_adder16 dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    always @(negedge clk)
        if (bus.done) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (result %h)", bus.result);
            end else begin
                e = q.pop_front();
                chk("result", bus.result, e.r);
                chk("cout", {15'b0, bus.cout}, {15'b0, e.c});
                chk("overflow", {15'b0, bus.overflow}, {15'b0, e.v});
                chk("zero", {15'b0, bus.zero}, {15'b0, e.z});
            end
        end
    task automatic op(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [15:0] r, input logic c, input logic v, input logic z);
        bus.a = a;
        bus.b = b;
        bus.sub = s;
        bus.start = 1'b1;
        q.push_back('{r: r, c: c, v: v, z: z});
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask
    task automatic wait_done(output int n);
        n = 0;
        while (1) begin
            @(posedge clk);
            #1 n++;
            if (bus.done) break;
            if (n >= 20) begin
                vectors++;
                miscompares++;
                $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
                break;
            end
        end
    endtask
    initial begin
        reset = 1'b1;
        bus.start = 1'b1;
        bus.sub = 1'b0;
        bus.a = 16'h0001;
        bus.b = 16'h0001;
`ifdef NIBBLE_ADDER_CARRY_CHAIN_EN
        bus.use_carry = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {15'b0, bus.busy}, 16'h0);
        chk("rst_done", {15'b0, bus.done}, 16'h0);
        chk("rst_result", bus.result, 16'h0000);
        chk("rst_flags", {13'b0, bus.cout, bus.overflow, bus.zero}, 16'h0);
        reset = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1 chk("rst_no_accept", {15'b0, bus.busy}, 16'h0);
        op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        chk("run_busy", {15'b0, bus.busy}, 16'h1);
        wait_done(lat);
        chk("latency", 16'(lat), 16'd4);
        chk("done_busy_low", {15'b0, bus.busy}, 16'h0);
        @(posedge clk);
        #1 chk("done_one_cycle", {15'b0, bus.done}, 16'h0);
        op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        wait_done(lat);
        op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        wait_done(lat);
        @(posedge clk);
        op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.a = 16'hFFFF;
        bus.b = 16'hFFFF;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.a = 16'hAAAA;
        wait_done(lat);
        repeat (2) @(posedge clk);
        #1 chk("run_start_ignored", {15'b0, bus.busy}, 16'h0);
        chk("result_hold_idle", bus.result, 16'h1000);
        bus.a = 16'h1111;
        bus.b = 16'h2222;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1 chk("result_hold_run", bus.result, 16'h1000);
        reset = 1'b1;
        @(posedge clk);
        #1 chk("abort_busy", {15'b0, bus.busy}, 16'h0);
        chk("abort_result", bus.result, 16'h0000);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("abort_no_done", {15'b0, bus.done}, 16'h0);
        op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
        wait_done(lat);
        op(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0);
        wait_done(lat);
        op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        chk("b2b_no_gap", {15'b0, bus.busy}, 16'h1);
        wait_done(lat);
        chk("b2b_latency", 16'(lat), 16'd4);
`ifdef NIBBLE_ADDER_CARRY_CHAIN_EN
        @(posedge clk);
        op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        wait_done(lat);
        @(posedge clk);
        bus.use_carry = 1'b1;
        op(16'h0000, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0);
        bus.use_carry = 1'b0;
        wait_done(lat);
`endif
        repeat (3) @(posedge clk);
        #1 chk("pending", 16'(q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder16.md
Name: nibble_serial_adder16

Overview:
- Multi-cycle 16-bit add/subtract unit for the 16-bit datapath ALU.
- Processes the operands as four 4-bit nibbles, least significant first, through a single internal 4-bit ripple adder slice, one nibble per clock.
- Carry is held in a register between nibbles.
- Trades four cycles of latency for one adder slice.
- Sits between the register-file operand buses and the ALU result/flags register.

Parameters:
- NIBBLES, 4, number of 4-bit slices processed; fixed at 4 for a 16-bit word. Other values are unsupported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only when idle or done
- sub  input  1  0 = A+B, 1 = A-B; sampled with start
- a  input  16  operand A; sampled with start
- b  input  16  operand B; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when result and flags are valid and updated
- result  output  16  registered sum or difference
- cout  output  1  carry out of bit 15; for subtract, 1 = no borrow
- overflow  output  1  two's-complement signed overflow
- zero  output  1  result == 16'h0000

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: busy=0, done=0, result=0, cout=0, overflow=0, zero=0. The FSM goes to IDLE and the nibble counter goes to 0.
- FSM states:
  - IDLE: start=1 at edge E0 latches a, sub, and b (b is inverted when sub=1). Carry register <= sub. Counter <= 0. Next state RUN, busy=1.
  - RUN: each edge adds nibble[cnt] of A and B' plus the carry. The sum nibble is written into an internal 16-bit accumulator at position cnt, the carry register is updated, and cnt increments.
  - RUN to DONE: at the edge where cnt==3 (edge E4), the unit:
    - loads result from the accumulator, including the final nibble;
    - loads cout from the final carry;
    - computes overflow = (A[15]==B'[15]) && (S[15]!=A[15]);
    - computes zero from the full 16-bit result;
    - sets state DONE, busy=0, done=1.
  - DONE: lasts exactly one cycle. start=1 here is accepted exactly as in IDLE (back-to-back operation, next state RUN). Otherwise next state is IDLE and done=0.
- Latency: done is high in the cycle after E4, 4 cycles after the accept edge. Throughput is one operation per 4 cycles with back-to-back start.
- result and the flags change only at completion. They hold their last values through IDLE and through a subsequent RUN.
- start while in RUN is ignored. No queuing.
- Operand changes after the accept edge have no effect.
- Reset mid-operation aborts the operation. Outputs return to their reset values at that edge, and no done pulse is produced.
- Reset and start in the same cycle: reset wins.
- Arithmetic is modulo 2^16. Subtraction is A + ~B + 1.

Optional Feature:
- NIBBLE_ADDER_CARRY_CHAIN_EN defined:
  - Adds input port use_carry (1 bit), sampled with start.
  - When use_carry=1, the initial carry is the stored cout from the previous completed operation instead of sub. This gives ADC/SBB multi-word arithmetic.
  - Stored cout is cleared by reset.
- Macro not defined: the port is absent and the initial carry is always sub.

Test Plan:
1. Assert reset for 2 cycles with start=1 -> busy=0, done=0, result=0x0000, all flags 0, no operation accepted.
2. Add, a=0x1234, b=0x4321 -> busy=1 for 4 cycles, done pulses one cycle after E4; result=0x5555, cout=0, overflow=0, zero=0.
3. Add, a=0xFFFF, b=0x0001 -> result=0x0000, cout=1, zero=1, overflow=0. Then sub, a=0x8000, b=0x0001 -> result=0x7FFF, cout=1, overflow=1.
4. Start add 0x0F0F+0x00F1, pulse start with new operands during RUN, and change a/b mid-operation -> single done; result=0x1000; second start ignored.
5. Start an operation and assert reset at E2 -> busy=0, result=0 at that edge, no done pulse; the next start completes normally.
6. Start asserted in the DONE cycle with sub, a=0x0005, b=0x0007 -> accepted with no idle gap; result=0xFFFE, cout=0. With NIBBLE_ADDER_CARRY_CHAIN_EN defined: 0xFFFF+0x0001, then use_carry=1 with 0x0000+0x0000 -> result=0x0001.
